ahb_data_ram: RTL

Parametrised AHB-Lite data-memory slave with byte, halfword and word accesses, configurable depth and wait states, and an ERROR response for misaligned and out-of-range transfers. It sits on the SoC bus behind the address decoder, selected by HSEL, and replaces the single-width fixed-size data RAM. Reads are registered, with write-to-read forwarding, and writes are byte-lane masked.

---
 rtl/ahb_pkg.sv | 36 +++
 rtl/data_ram_bank.sv | 28 ++
 rtl/ahb_data_ram.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, response codes, RAM slave state type and lane-mask helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } ahb_ram_state_t;

  // Little-endian byte lanes touched by an access; illegal sizes touch nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// Word-wide storage with per-byte write enables and a registered read port.
module data_ram_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage deliberately has no reset so it maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_data_ram.sv
// AHB-Lite data RAM slave: decode/error check, wait-state FSM, write commit and
// same-edge write-to-read forwarding in front of a byte-masked RAM bank.
module ahb_data_ram
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb_ram_state_t state_q;
  logic [3:0]     wcnt_q;
  logic [AW-1:0]  waddr_q;
  logic [1:0]     addr_lo_q;
  logic [2:0]     size_q;
  logic           write_q;
  logic           err_q;
  logic           rd_q;
  logic [3:0]     fwd_be_q;
  logic [31:0]    fwd_data_q;

  logic [31:0]   offset;
  logic [AW-1:0] word_addr;
  logic          range_err, size_err, align_err, xfer_err;
  logic          can_accept, accept, commit, rd_en;
  logic [3:0]    commit_be;
  logic [31:0]   bank_rdata, fwd_bits, merged;
  logic          unused_bits;

  assign offset    = HADDR - BASE_ADDR;
  assign word_addr = offset[AW+1:2];

  assign range_err = offset >= 32'(DEPTH_BYTES);
  assign size_err  = HSIZE > HSIZE_WORD;
  assign align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign xfer_err  = range_err || size_err || align_err;

  assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept     = HSEL && HTRANS[1] && HREADY && can_accept;
  assign rd_en      = accept && !xfer_err && !HWRITE;

  assign commit    = (state_q == StData) && write_q && !err_q;
  assign commit_be = lane_mask(size_q, addr_lo_q);

  assign unused_bits = ^{offset[1:0], HTRANS[0]};

  data_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .we    (commit),
    .be    (commit_be),
    .waddr (waddr_q),
    .wdata (HWDATA),
    .re    (rd_en),
    .raddr (word_addr),
    .rdata (bank_rdata)
  );

  assign fwd_bits = {{8{fwd_be_q[3]}}, {8{fwd_be_q[2]}}, {8{fwd_be_q[1]}}, {8{fwd_be_q[0]}}};
  assign merged   = (bank_rdata & ~fwd_bits) | (fwd_data_q & fwd_bits);
  assign HRDATA   = rd_q ? merged : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      waddr_q    <= '0;
      addr_lo_q  <= 2'b00;
      size_q     <= HSIZE_BYTE;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'h0;
      HREADYOUT  <= 1'b1;
      HRESP      <= HRESP_OKAY;
    end else if (accept) begin
      waddr_q    <= word_addr;
      addr_lo_q  <= HADDR[1:0];
      size_q     <= HSIZE;
      write_q    <= HWRITE;
      err_q      <= xfer_err;
      rd_q       <= !xfer_err && !HWRITE;
      // A write retiring on this edge is invisible to the bank read; replay its lanes.
      fwd_be_q   <= (commit && (waddr_q == word_addr)) ? commit_be : 4'b0000;
      fwd_data_q <= HWDATA;
      if (xfer_err) begin
        state_q   <= StErr1;
        HREADYOUT <= 1'b0;
        HRESP     <= HRESP_ERROR;
      end else if (WAIT_STATES > 0) begin
        state_q   <= StWait;
        wcnt_q    <= WCNT_INIT;
        HREADYOUT <= 1'b0;
        HRESP     <= HRESP_OKAY;
      end else begin
        state_q   <= StData;
        HREADYOUT <= 1'b1;
        HRESP     <= HRESP_OKAY;
      end
    end else begin
      case (state_q)
        StWait: begin
          if (wcnt_q == 4'd0) begin
            state_q   <= StData;
            HREADYOUT <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q   <= StErr2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          state_q   <= StIdle;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          write_q   <= 1'b0;
          err_q     <= 1'b0;
          rd_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
